// File: rtl/gestion_memoire_param.sv
// Memory access sequencer: turns changes on the user address/data inputs into strobed
// read or write cycles on an external memory bus, with optional write read-back check.
module gestion_memoire_param #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 7,
    parameter int LATCH_W = 1,
    parameter int VERIFY  = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] AddIn,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              ReadReq,
    input  logic [DATA_W-1:0] DataBusOut,
    output logic [ADDR_W-1:0] AddOut,
    output logic [DATA_W-1:0] DataBusIn,
    output logic              Latch,
    output logic              RW,
    output logic [DATA_W-1:0] DataOut,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, HOLD, RB_SETUP, RB_STROBE, RB_HOLD
    } state_t;

    localparam logic [3:0] STROBE_LAST = 4'(LATCH_W - 1);

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] add_snap, add_snap_n, add_out_n;
    logic [DATA_W-1:0] data_snap, data_snap_n, data_bus_in_n, data_out_n;
    logic              latch_n, rw_n, busy_n, done_n, err_n;

    always_ff @(negedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            add_snap  <= AddIn;
            data_snap <= DataIn;
            AddOut    <= '0;
            DataBusIn <= '0;
            DataOut   <= '0;
            Latch     <= 1'b0;
            RW        <= 1'b1;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            add_snap  <= add_snap_n;
            data_snap <= data_snap_n;
            AddOut    <= add_out_n;
            DataBusIn <= data_bus_in_n;
            DataOut   <= data_out_n;
            Latch     <= latch_n;
            RW        <= rw_n;
            Busy      <= busy_n;
            Done      <= done_n;
            Err       <= err_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        add_snap_n    = add_snap;
        data_snap_n   = data_snap;
        add_out_n     = AddOut;
        data_bus_in_n = DataBusIn;
        data_out_n    = DataOut;
        latch_n       = Latch;
        rw_n          = RW;
        busy_n        = Busy;
        done_n        = 1'b0;
        err_n         = Err;

        case (state)
            IDLE: begin
                // A data change wins over an address change, which wins over ReadReq.
                if (DataIn != data_snap || AddIn != add_snap || ReadReq) begin
                    add_out_n   = AddIn;
                    add_snap_n  = AddIn;
                    data_snap_n = DataIn;
                    busy_n      = 1'b1;
                    err_n       = 1'b0;
                    state_n     = SETUP;
                    if (DataIn != data_snap) begin
                        rw_n          = 1'b0;
                        data_bus_in_n = DataIn;
                    end else begin
                        rw_n = 1'b1;
                    end
                end
            end
            SETUP: begin
                latch_n = 1'b1;
                cnt_n   = 4'd0;
                state_n = STROBE;
            end
            STROBE: begin
                if (cnt == STROBE_LAST) begin
                    latch_n = 1'b0;
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            HOLD: begin
                if (VERIFY != 0 && !RW) begin
                    rw_n    = 1'b1;
                    cnt_n   = 4'd0;
                    state_n = RB_SETUP;
                end else begin
                    data_out_n = DataBusOut;
                    done_n     = 1'b1;
                    busy_n     = 1'b0;
                    state_n    = IDLE;
                end
            end
            // Two setup cycles after RW flips give the bus a turnaround before the strobe.
            RB_SETUP: begin
                if (cnt == 4'd1) begin
                    latch_n = 1'b1;
                    cnt_n   = 4'd0;
                    state_n = RB_STROBE;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            RB_STROBE: begin
                if (cnt == STROBE_LAST) begin
                    latch_n = 1'b0;
                    state_n = RB_HOLD;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            RB_HOLD: begin
                data_out_n = DataBusOut;
                err_n      = (DataBusOut != DataBusIn);
                done_n     = 1'b1;
                busy_n     = 1'b0;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gestion_memoire_param.sv
// Bench for gestion_memoire_param: a default instance and a VERIFY=1/LATCH_W=3 instance
// share the same stimulus; directed tables, hand sequences and a randomized model run.
module tb_gestion_memoire_param;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [6:0] AddIn = '0, DataIn = '0, DataBusOut = '0;
    logic       ReadReq = 1'b0;

    logic [6:0] add0, dbi0, dout0, add1, dbi1, dout1;
    logic       latch0, rw0, busy0, done0, err0, latch1, rw1, busy1, done1, err1;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    gestion_memoire_param dut0 (
        .Clk(Clk), .Rst(Rst), .AddIn(AddIn), .DataIn(DataIn), .ReadReq(ReadReq),
        .DataBusOut(DataBusOut), .AddOut(add0), .DataBusIn(dbi0), .Latch(latch0),
        .RW(rw0), .DataOut(dout0), .Busy(busy0), .Done(done0), .Err(err0)
    );

    gestion_memoire_param #(.ADDR_W(7), .DATA_W(7), .LATCH_W(3), .VERIFY(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .AddIn(AddIn), .DataIn(DataIn), .ReadReq(ReadReq),
        .DataBusOut(DataBusOut), .AddOut(add1), .DataBusIn(dbi1), .Latch(latch1),
        .RW(rw1), .DataOut(dout1), .Busy(busy1), .Done(done1), .Err(err1)
    );

    // Transaction-level reference: each operation is described by its elapsed cycle count t.
    bit       m_inop[2], m_wr[2], m_latch[2], m_rw[2], m_busy[2], m_done[2], m_err[2];
    int       m_t[2];
    logic [6:0] m_add[2], m_dbi[2], m_dout[2], m_sa[2], m_sd[2];

    task automatic model_step(input int i);
        int L, D;
        bit wv;
        L = (i == 0) ? 1 : 3;
        if (Rst) begin
            m_inop[i] = 0; m_latch[i] = 0; m_rw[i] = 1; m_busy[i] = 0; m_done[i] = 0;
            m_err[i] = 0; m_add[i] = '0; m_dbi[i] = '0; m_dout[i] = '0;
            m_sa[i] = AddIn; m_sd[i] = DataIn;
        end else begin
            m_done[i] = 0;
            if (m_inop[i]) begin
                m_t[i]++;
                wv = (i == 1) && m_wr[i];
                D = wv ? 2 * L + 5 : L + 2;
                m_latch[i] = (m_t[i] >= 1 && m_t[i] <= L) ||
                             (wv && m_t[i] >= L + 4 && m_t[i] <= 2 * L + 3);
                if (wv && m_t[i] >= L + 2) m_rw[i] = 1;
                if (m_t[i] == D) begin
                    m_dout[i] = DataBusOut;
                    if (wv) m_err[i] = (DataBusOut != m_dbi[i]);
                    m_done[i] = 1; m_busy[i] = 0; m_inop[i] = 0;
                end
            end else if (DataIn != m_sd[i] || AddIn != m_sa[i] || ReadReq) begin
                m_wr[i] = (DataIn != m_sd[i]);
                m_inop[i] = 1; m_t[i] = 0; m_add[i] = AddIn;
                if (m_wr[i]) m_dbi[i] = DataIn;
                m_rw[i] = !m_wr[i]; m_busy[i] = 1; m_err[i] = 0; m_latch[i] = 0;
                m_sa[i] = AddIn; m_sd[i] = DataIn;
            end
        end
    endtask

    task automatic step();
        @(negedge Clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [6:0] add, dat;
        logic       rr;
        logic [6:0] dbo;
        logic       latch, rw, busy, done, err;
        logic [6:0] addout, dbi, dout;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // rst add dat rr dbo | latch rw busy done err | addout dbi dout
        tbl[0]  = '{1'b1, 7'h00, 7'h00, 1'b0, 7'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, 7'h00};
        tbl[1]  = '{1'b0, 7'h12, 7'h00, 1'b0, 7'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'h12, 7'h00, 7'h00};
        tbl[2]  = '{1'b0, 7'h12, 7'h00, 1'b0, 7'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'h12, 7'h00, 7'h00};
        tbl[3]  = '{1'b0, 7'h12, 7'h00, 1'b0, 7'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'h12, 7'h00, 7'h00};
        tbl[4]  = '{1'b0, 7'h12, 7'h00, 1'b0, 7'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'h12, 7'h00, 7'h55};
        tbl[5]  = '{1'b0, 7'h12, 7'h00, 1'b0, 7'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h12, 7'h00, 7'h55};
        tbl[6]  = '{1'b0, 7'h12, 7'h00, 1'b1, 7'h66, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'h12, 7'h00, 7'h55};
        tbl[7]  = '{1'b0, 7'h12, 7'h00, 1'b0, 7'h66, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'h12, 7'h00, 7'h55};
        tbl[8]  = '{1'b0, 7'h12, 7'h00, 1'b0, 7'h66, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'h12, 7'h00, 7'h55};
        tbl[9]  = '{1'b0, 7'h12, 7'h00, 1'b0, 7'h66, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'h12, 7'h00, 7'h66};
        tbl[10] = '{1'b0, 7'h05, 7'h2A, 1'b0, 7'h66, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h05, 7'h2A, 7'h66};
        tbl[11] = '{1'b0, 7'h05, 7'h2A, 1'b0, 7'h66, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'h05, 7'h2A, 7'h66};
        tbl[12] = '{1'b0, 7'h05, 7'h2A, 1'b0, 7'h66, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h05, 7'h2A, 7'h66};
        tbl[13] = '{1'b0, 7'h05, 7'h2A, 1'b0, 7'h66, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h05, 7'h2A, 7'h66};
        tbl[14] = '{1'b0, 7'h05, 7'h2A, 1'b0, 7'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h05, 7'h2A, 7'h66};

        repeat (2) step();
        for (int k = 0; k < 15; k++) begin
            Rst = tbl[k].rst; AddIn = tbl[k].add; DataIn = tbl[k].dat;
            ReadReq = tbl[k].rr; DataBusOut = tbl[k].dbo;
            step();
            chk($sformatf("tbl%0d latch", k), 32'(latch0), 32'(tbl[k].latch));
            chk($sformatf("tbl%0d rw", k),    32'(rw0),    32'(tbl[k].rw));
            chk($sformatf("tbl%0d busy", k),  32'(busy0),  32'(tbl[k].busy));
            chk($sformatf("tbl%0d done", k),  32'(done0),  32'(tbl[k].done));
            chk($sformatf("tbl%0d err", k),   32'(err0),   32'(tbl[k].err));
            chk($sformatf("tbl%0d addout", k), 32'(add0),  32'(tbl[k].addout));
            chk($sformatf("tbl%0d dbi", k),   32'(dbi0),   32'(tbl[k].dbi));
            chk($sformatf("tbl%0d dout", k),  32'(dout0),  32'(tbl[k].dout));
        end

        // Write with read-back, memory returns a corrupted value.
        Rst = 1; AddIn = 7'h05; DataIn = 7'h00; ReadReq = 0; DataBusOut = 7'h32;
        repeat (2) step();
        Rst = 0;
        step();
        chk("rb idle after release", 32'(busy1), 32'd0);
        DataIn = 7'h33;
        for (int t = 0; t <= 12; t++) begin
            step();
            chk($sformatf("rb t%0d latch", t), 32'(latch1),
                32'((t >= 1 && t <= 3) || (t >= 7 && t <= 9)));
            chk($sformatf("rb t%0d rw", t), 32'(rw1), 32'(t >= 5));
            chk($sformatf("rb t%0d busy", t), 32'(busy1), 32'(t <= 10));
            chk($sformatf("rb t%0d done", t), 32'(done1), 32'(t == 11));
            chk($sformatf("rb t%0d addout", t), 32'(add1), 32'h05);
            chk($sformatf("rb t%0d dbi", t), 32'(dbi1), 32'h33);
        end
        chk("rb err held", 32'(err1), 32'd1);
        chk("rb dout", 32'(dout1), 32'h32);

        // Address change during the strobe is held off until after Done.
        Rst = 1; AddIn = 7'h00; DataIn = 7'h33;
        repeat (2) step();
        Rst = 0;
        step();
        AddIn = 7'h12;
        step();
        chk("ovl t0 addout", 32'(add0), 32'h12);
        AddIn = 7'h20;
        step();
        chk("ovl t1 latch", 32'(latch0), 32'd1);
        chk("ovl t1 addout", 32'(add0), 32'h12);
        step();
        step();
        chk("ovl t3 done", 32'(done0), 32'd1);
        chk("ovl t3 addout", 32'(add0), 32'h12);
        step();
        chk("ovl t4 busy", 32'(busy0), 32'd1);
        chk("ovl t4 addout", 32'(add0), 32'h20);
        chk("ovl t4 rw", 32'(rw0), 32'd1);
        repeat (3) step();
        chk("ovl t7 done", 32'(done0), 32'd1);

        // Reset during the strobe aborts without a Done pulse.
        step();
        AddIn = 7'h44;
        step();
        step();
        chk("rst strobe latch", 32'(latch0), 32'd1);
        Rst = 1;
        step();
        chk("rst latch", 32'(latch0), 32'd0);
        chk("rst busy", 32'(busy0), 32'd0);
        chk("rst done", 32'(done0), 32'd0);
        chk("rst rw", 32'(rw0), 32'd1);
        chk("rst addout", 32'(add0), 32'd0);
        chk("rst dbi", 32'(dbi0), 32'd0);
        chk("rst dout", 32'(dout0), 32'd0);
        chk("rst err1", 32'(err1), 32'd0);
        Rst = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post rst%0d busy", k), 32'(busy0), 32'd0);
            chk($sformatf("post rst%0d done", k), 32'(done0), 32'd0);
        end

        // Randomized run against the reference model.
        Rst = 1;
        repeat (2) step();
        Rst = 0;
        for (int c = 0; c < 1500 && errors < 40; c++) begin
            int r;
            r = $urandom_range(0, 99);
            ReadReq = 0;
            if (r < 6) DataIn = 7'($urandom);
            else if (r < 12) AddIn = 7'($urandom);
            else if (r < 16) ReadReq = 1;
            Rst = ($urandom_range(0, 199) == 0);
            DataBusOut = $urandom_range(0, 1) ? dbi1 : 7'($urandom);
            step();
            chk("rnd0 latch", 32'(latch0), 32'(m_latch[0]));
            chk("rnd0 rw",    32'(rw0),    32'(m_rw[0]));
            chk("rnd0 busy",  32'(busy0),  32'(m_busy[0]));
            chk("rnd0 done",  32'(done0),  32'(m_done[0]));
            chk("rnd0 err",   32'(err0),   32'(m_err[0]));
            chk("rnd0 addout", 32'(add0),  32'(m_add[0]));
            chk("rnd0 dbi",   32'(dbi0),   32'(m_dbi[0]));
            chk("rnd0 dout",  32'(dout0),  32'(m_dout[0]));
            chk("rnd1 latch", 32'(latch1), 32'(m_latch[1]));
            chk("rnd1 rw",    32'(rw1),    32'(m_rw[1]));
            chk("rnd1 busy",  32'(busy1),  32'(m_busy[1]));
            chk("rnd1 done",  32'(done1),  32'(m_done[1]));
            chk("rnd1 err",   32'(err1),   32'(m_err[1]));
            chk("rnd1 addout", 32'(add1),  32'(m_add[1]));
            chk("rnd1 dbi",   32'(dbi1),   32'(m_dbi[1]));
            chk("rnd1 dout",  32'(dout1),  32'(m_dout[1]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
